// File: rtl/result_demux_pkg.sv
// Shared definitions for the result distributor and the select mux: destination
// indices, slot state encoding and the common (ctrl1, ctrl2) decode.
package result_demux_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NUM_DEST  = 3;

    localparam logic [1:0] DEST_WB = 2'd0;
    localparam logic [1:0] DEST_PC = 2'd1;
    localparam logic [1:0] DEST_ST = 2'd2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // ctrl2 dominates so the mux and the demux resolve (1,1) to the same port.
    function automatic logic [1:0] decode_dest(input logic ctrl1, input logic ctrl2);
        if (ctrl2) begin
            return DEST_ST;
        end else if (ctrl1) begin
            return DEST_PC;
        end else begin
            return DEST_WB;
        end
    endfunction

endpackage

// File: rtl/result_slot.sv
// One-entry output buffer with valid/ready drain and a wrapping delivery counter.
module result_slot
    import result_demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    slot_state_e      state_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             drain;

    assign drain   = (state_q == SLOT_FULL) && ready_i;
    assign count_d = count_q + CNT_W'(1);

    // Data is kept after a drain; only a new load overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                SLOT_EMPTY: if (load_i) state_q <= SLOT_FULL;
                SLOT_FULL:  if (ready_i && !load_i) state_q <= SLOT_EMPTY;
                default:    state_q <= SLOT_EMPTY;
            endcase
            if (load_i) begin
                data_q <= data_i;
            end
            if (drain) begin
                count_q <= count_d;
            end
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;
    assign count_o = count_q;

endmodule

// File: rtl/result_demux.sv
// Routes one result word per cycle to write-back, PC update or store-data
// through a registered one-entry slot per destination.
module result_demux
    import result_demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_ctrl1,
    input  logic             in_ctrl2,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [CNT_W-1:0] out0_count,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] out1_count,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic [CNT_W-1:0] out2_count
);

    logic [1:0] dest;
    logic       accept;
    logic       load0;
    logic       load1;
    logic       load2;

    assign dest = decode_dest(in_ctrl1, in_ctrl2);

    // Only the addressed slot gates acceptance; the other ports never stall input.
    always_comb begin
        in_ready = 1'b1;
        case (dest)
            DEST_WB: in_ready = !out0_valid || out0_ready;
            DEST_PC: in_ready = !out1_valid || out1_ready;
            DEST_ST: in_ready = !out2_valid || out2_ready;
            default: in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign load0  = accept && (dest == DEST_WB);
    assign load1  = accept && (dest == DEST_PC);
    assign load2  = accept && (dest == DEST_ST);

    result_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_wb (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load0),
        .data_i  (in_data),
        .ready_i (out0_ready),
        .valid_o (out0_valid),
        .data_o  (out0_data),
        .count_o (out0_count)
    );

    result_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_pc (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load1),
        .data_i  (in_data),
        .ready_i (out1_ready),
        .valid_o (out1_valid),
        .data_o  (out1_data),
        .count_o (out1_count)
    );

    result_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_st (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load2),
        .data_i  (in_data),
        .ready_i (out2_ready),
        .valid_o (out2_valid),
        .data_o  (out2_data),
        .count_o (out2_count)
    );

endmodule

// File: tb/tb_result_demux.sv
// Scoreboard bench for result_demux: per-port expected-word queues fed on accept,
// compared by a negedge monitor against the DUT outputs.
module tb_result_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        c1;
    logic        c2;
    logic [31:0] din;
    logic [2:0]  rdy;
    logic [2:0]  ov;
    logic [31:0] od [3];
    logic [7:0]  oc [3];

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] exp_q [3][$];
    logic [31:0] last_ld [3];
    int          delivered [3];

    always #5 clk = ~clk;

    result_demux #(.WIDTH(32), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl1   (c1),
        .in_ctrl2   (c2),
        .in_data    (din),
        .out0_valid (ov[0]),
        .out0_ready (rdy[0]),
        .out0_data  (od[0]),
        .out0_count (oc[0]),
        .out1_valid (ov[1]),
        .out1_ready (rdy[1]),
        .out1_data  (od[1]),
        .out1_count (oc[1]),
        .out2_valid (ov[2]),
        .out2_ready (rdy[2]),
        .out2_data  (od[2]),
        .out2_count (oc[2])
    );

    function automatic int dest_of(input logic k1, input logic k2);
        if (k2) return 2;
        if (k1) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a port holds at most the words accepted but not yet taken.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 3; n++) begin
                exp_q[n].delete();
                last_ld[n]   = '0;
                delivered[n] = 0;
            end
        end else begin
            int  d;
            bit  acc;
            bit  take [3];
            d   = dest_of(c1, c2);
            acc = in_valid && ((exp_q[d].size() == 0) || rdy[d]);
            for (int n = 0; n < 3; n++) take[n] = (exp_q[n].size() != 0) && rdy[n];
            for (int n = 0; n < 3; n++) begin
                if (take[n]) begin
                    void'(exp_q[n].pop_front());
                    delivered[n] = delivered[n] + 1;
                end
            end
            if (acc) begin
                exp_q[d].push_back(din);
                last_ld[d] = din;
            end
        end
    end

    // Monitor: compare every output against the model between edges.
    always @(negedge clk) begin
        if (!rst) begin
            for (int n = 0; n < 3; n++) begin
                chk($sformatf("out%0d_valid", n), 64'(ov[n]), 64'(exp_q[n].size() != 0));
                if (ov[n] && exp_q[n].size() != 0)
                    chk($sformatf("out%0d_data", n), 64'(od[n]), 64'(exp_q[n][0]));
                else
                    chk($sformatf("out%0d_data_hold", n), 64'(od[n]), 64'(last_ld[n]));
                chk($sformatf("out%0d_count", n), 64'(oc[n]), 64'(delivered[n] % 256));
            end
            chk("in_ready", 64'(in_ready),
                64'((exp_q[dest_of(c1, c2)].size() == 0) || rdy[dest_of(c1, c2)]));
        end
    end

    task automatic drive(input logic v, input logic k1, input logic k2,
                         input logic [31:0] d, input logic [2:0] r);
        @(negedge clk);
        #2;
        in_valid = v;
        c1       = k1;
        c2       = k2;
        din      = d;
        rdy      = r;
    endtask

    task automatic check_reset_state(input string tag);
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("%s_out%0d_valid", tag, n), 64'(ov[n]), 64'd0);
            chk($sformatf("%s_out%0d_data", tag, n), 64'(od[n]), 64'd0);
            chk($sformatf("%s_out%0d_count", tag, n), 64'(oc[n]), 64'd0);
        end
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check_reset_state(tag);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        c1       = 1'b0;
        c2       = 1'b0;
        din      = '0;
        rdy      = 3'b111;
        repeat (2) @(posedge clk);
        #3;
        check_reset_state("por");
        rst = 1'b0;

        // Decode sweep.
        drive(1'b1, 1'b0, 1'b0, 32'hA000_0000, 3'b111);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_00B1, 3'b111);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_00C2, 3'b111);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_00D3, 3'b111);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b111);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b111);
        #1;
        chk("sweep_count0", 64'(oc[0]), 64'd1);
        chk("sweep_count1", 64'(oc[1]), 64'd1);
        chk("sweep_count2", 64'(oc[2]), 64'd2);
        chk("sweep_data2", 64'(od[2]), 64'h0D3);

        // Backpressure on port 1 while port 0 keeps flowing.
        drive(1'b1, 1'b1, 1'b0, 32'h11, 3'b101);
        drive(1'b1, 1'b1, 1'b0, 32'h22, 3'b101);
        #1;
        chk("bp_in_ready_blocked", 64'(in_ready), 64'd0);
        chk("bp_held_data", 64'(od[1]), 64'h11);
        drive(1'b1, 1'b0, 1'b0, 32'h33, 3'b101);
        #1;
        chk("bp_port0_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 1'b1, 1'b0, 32'h22, 3'b111);
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b111);
        #1;
        chk("bp_second_valid", 64'(ov[1]), 64'd1);
        chk("bp_second_data", 64'(od[1]), 64'h22);

        // Simultaneous drain and load on port 2.
        drive(1'b1, 1'b0, 1'b1, 32'h5, 3'b111);
        drive(1'b1, 1'b0, 1'b1, 32'h6, 3'b111);
        #1;
        chk("dl_first", 64'(od[2]), 64'h5);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b111);
        #1;
        chk("dl_valid", 64'(ov[2]), 64'd1);
        chk("dl_data", 64'(od[2]), 64'h6);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b111);

        // Counter wrap: 257 handshakes on port 0 from a clean reset.
        async_reset("wrap_rst");
        for (int i = 0; i < 257; i++) drive(1'b1, 1'b0, 1'b0, 32'(i + 1000), 3'b111);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b111);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b111);
        #1;
        chk("wrap_count0", 64'(oc[0]), 64'd1);

        // Reset with all three slots full.
        drive(1'b1, 1'b0, 1'b0, 32'hAA, 3'b000);
        drive(1'b1, 1'b1, 1'b0, 32'hBB, 3'b000);
        drive(1'b1, 1'b0, 1'b1, 32'hCC, 3'b000);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
        #1;
        chk("full_v0", 64'(ov[0]), 64'd1);
        chk("full_v1", 64'(ov[1]), 64'd1);
        chk("full_v2", 64'(ov[2]), 64'd1);
        async_reset("mid_rst");
        drive(1'b1, 1'b0, 1'b0, 32'h77, 3'b111);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b111);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b111);
        #1;
        chk("post_rst_count0", 64'(oc[0]), 64'd1);
        chk("post_rst_data0", 64'(od[0]), 64'h77);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                             $urandom_range(0, 3) != 0});
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b111);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b111);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/result_demux.md
# result_demux

Three-way result distributor for the datapath: the 1-to-3 counterpart of the 3-input select mux. It accepts one 32-bit word per cycle with a two-bit destination select (ctrl1, ctrl2), using the same encoding the select mux uses. It delivers the word to one of three destination ports through a registered one-entry slot per port, with valid/ready handshakes. It sits between the execute/memory stage result bus and its three consumers: write-back, PC update and store-data path.

## Interface
Parameters:
- WIDTH, 32, data word width
- CNT_W, 8, width of each per-port delivery counter

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  producer offers a word
- in_ready  output  1  word accepted this cycle when in_valid && in_ready
- in_ctrl1  input  1  destination select bit 1
- in_ctrl2  input  1  destination select bit 2
- in_data  input  WIDTH  word to route
- outN_valid  output  1  slot N holds a word (N = 0, 1, 2)
- outN_ready  input  1  consumer N takes the word when outN_valid && outN_ready
- outN_data  output  WIDTH  slot N word
- outN_count  output  CNT_W  words delivered on port N, wraps modulo 2^CNT_W

## Operation
- Destination decode, identical to the select mux:
  - ctrl2=1 → port 2, regardless of ctrl1
  - ctrl1=0, ctrl2=0 → port 0
  - ctrl1=1, ctrl2=0 → port 1
- Each port has a one-entry slot with two states:
  - EMPTY: outN_valid=0
  - FULL: outN_valid=1
- Slot transitions:
  - EMPTY → FULL on accept to N
  - FULL → EMPTY on drain (outN_ready=1) with no accept to N
  - FULL → FULL, data replaced, on simultaneous drain and accept to N
  - FULL holds its data unchanged while outN_ready=0
- in_ready = !outD_valid || outD_ready, where D is the decoded destination of the current ctrl bits.
  - Combinational from ctrl and outD_ready only.
  - Independent of in_valid.
  - Independent of the other two ports.
- Only the selected slot can load. Other ports continue draining independently in the same cycle.
- outN_count increments by 1 on each output handshake. It wraps from 2^CNT_W-1 to 0. No saturation and no flag.
- No reordering: each port's words leave in acceptance order. Capacity is 1 word per port.
- Changing ctrl while in_valid=1 and in_ready=0 is legal. in_ready is re-evaluated for the new destination.

## Timing
- Latency: a word accepted in cycle t appears on outN_data with outN_valid=1 in cycle t+1.
- Throughput: 1 word/cycle to one port while its consumer holds outN_ready=1.
- outN_data and outN_valid are driven directly from registers, with no combinational path from inputs.
- Reset values:
  - all outN_valid=0
  - all outN_data=0
  - all outN_count=0
  - in_ready=1 immediately (all slots EMPTY)
- Reset mid-operation:
  - Any held word is discarded asynchronously.
  - A handshake in the cycle rst deasserts counts normally from the first rising edge with rst=0.
- outN_data holds its last value after a drain until it is next loaded. It is not cleared on drain.

## Structure
- Shared package holds:
  - WIDTH default
  - destination index constants DEST_WB=0, DEST_PC=1, DEST_ST=2
  - the decode function (ctrl1, ctrl2) → index, also used by the select-mux control logic so both ends agree
- One sub-module, result_slot: the one-entry buffer plus delivery counter with load/drain handshake. It is instantiated three times. The top level contains only decode, in_ready generation and the load-enable fan-out.

## Test plan
- Reset check: assert rst asynchronously mid-cycle → all outN_valid=0, outN_data=0, outN_count=0, in_ready=1 before the next edge.
- Decode sweep: send 0xA0000000 with ctrl (0,0), 0xB1 with (1,0), 0xC2 with (0,1), 0xD3 with (1,1), all consumers ready → words appear one cycle later on ports 0, 1, 2, 2 respectively. Final counts are 1, 1, 2.
- Backpressure: out1_ready=0, send 0x11 then 0x22 to port 1 → 0x11 held on out1_data and in_ready=0 for the second word. A word sent to port 0 in the same cycle is accepted. Raise out1_ready → 0x22 is accepted in that same cycle and appears the next cycle.
- Simultaneous drain and load: port 2 FULL with 0x5, out2_ready=1, accept 0x6 to port 2 → out2_valid stays 1, out2_data=0x6 next cycle, out2_count +1.
- Counter wrap: with CNT_W=8, perform 257 handshakes on port 0 → out0_count=1.
- Reset mid-operation: all three slots FULL, pulse rst for 1 cycle → all slots EMPTY, counts 0, next accepted word delivered normally with count 1.
